fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of instruction_memory.
- Owns the program counter, drives the memory's address/valid request, and captures data on done.
- Buffers fetched {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap) from execute, which flushes all buffered and in-flight work.

Parameters:
- Width, 32, address and instruction width in bits.
- ResetPc, 0, PC value loaded at reset.
- FifoDepth, 2, number of {pc, instr} entries buffered toward decode; must be >= 2 and a power of 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- fetch_enable  input  1  1 = fetch allowed; 0 = stop issuing requests.
- imem_address  output  Width  byte address of the current request; always equals pc.
- imem_valid  output  1  request valid.
- imem_data  input  Width  instruction returned by memory.
- imem_ready  input  1  memory able to serve.
- imem_done  input  1  imem_data valid for the current request (may arrive in the same cycle as valid).
- redirect_valid  input  1  redirect strobe from execute.
- redirect_pc  input  Width  redirect target.
- if_valid  output  1  FIFO head valid toward decode.
- if_ready  input  1  decode accepts the head.
- if_instr  output  Width  head instruction.
- if_pc  output  Width  head PC.

Behaviour:
- Reset (async assert, sync-released by clk):
  - pc=ResetPc, FIFO empty, state=BOOT.
  - imem_valid=0, if_valid=0, if_instr=0, if_pc=0.
- State machine:
  - BOOT: exactly one cycle after reset release with imem_valid=0, then RUN.
  - RUN -> HALT when fetch_enable=0. HALT -> RUN when fetch_enable=1.
  - Transitions are registered and take effect the next cycle.
- Request rule: imem_valid = (state==RUN) && fifo_count<FifoDepth && !redirect_valid. It is combinational and does not look ahead at a same-cycle pop.
- imem_address = pc at all times. While imem_valid=1 and imem_done=0, pc holds, so the address stays stable until done.
- Response accept: when imem_valid && imem_ready && imem_done:
  - push {pc, imem_data} into the FIFO;
  - pc <= pc + Width/8, wrapping modulo 2^Width.
  - imem_done with imem_ready=0 or imem_valid=0 is ignored.
- Throughput:
  - With a combinational memory (done same cycle) and if_ready=1, one instruction per cycle sustained.
  - Latency from pc update to if_valid is 1 cycle (push registered, head visible next cycle).
- Decode handshake:
  - if_valid = FIFO not empty && !redirect_valid.
  - Pop when if_valid && if_ready.
  - if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- Simultaneous push and pop: count unchanged. Push is never blocked by the same-cycle pop result. When the FIFO is full, the request bubbles one cycle.
- Redirect (redirect_valid=1), valid in any state including HALT:
  - FIFO flushed to empty.
  - Any same-cycle response discarded.
  - pc <= {redirect_pc[Width-1:2], 2'b00}, i.e. misaligned low bits are cleared.
  - The first fetch from the target is issued next cycle if RUN.
  - Redirect in BOOT: pc is updated, and BOOT still lasts its one cycle.
- fetch_enable=0 mid-request: request abandoned (imem_valid drops next cycle), pc not advanced. The FIFO keeps draining to decode.
- Reset mid-operation: immediate return to reset values. FIFO contents and pc lost.
- FIFO pointers wrap modulo FifoDepth. Count width is $clog2(FifoDepth)+1.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, HALT};
  - fetch_entry_t packed struct {pc, instr} sized by Width;
  - InstrBytes = Width/8 and InstrAlignBits = $clog2(InstrBytes).
- Sub-module fetch_fifo:
  - parameterised synchronous FIFO of fetch_entry_t;
  - ports push/pop/flush/full/empty/count;
  - flush has priority over push.

Test Plan:
- Reset then run: memory words 0x00000013, 0x00100093, 0x00200113; fetch_enable=1, if_ready=1 -> imem_valid first high 1 cycle after release; if_pc 0x0, 0x4, 0x8 on consecutive cycles with matching if_instr.
- Backpressure: if_ready=0 from cycle 3 -> FIFO fills to 2, imem_valid drops, pc holds at 0x8, if_pc held at 0x0. Release if_ready -> 0x0, 0x4, 0x8 delivered in order, none lost or duplicated.
- Redirect with full FIFO and a same-cycle done: redirect_pc=0x40 -> if_valid=0 that cycle, FIFO empty next cycle, next imem_address=0x40, first if_pc=0x40.
- Misaligned redirect_pc=0x46 -> imem_address=0x44.
- Slow memory: imem_done delayed 3 cycles -> imem_address stable at 0x0 for all 4 cycles, a single push, pc then 0x4.
- fetch_enable low mid-request -> imem_valid=0 next cycle, pc unchanged, FIFO drains.
- Re-enable -> fetch resumes at the held pc.
- Async reset asserted mid-stream -> all outputs 0 immediately, pc=ResetPc on release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states and the {pc, instr}
// entry buffered toward decode.
package fetch_pkg;

    localparam int DataWidth      = 32;
    localparam int InstrBytes     = DataWidth / 8;
    localparam int InstrAlignBits = $clog2(InstrBytes);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DataWidth-1:0] pc;
        logic [DataWidth-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push.
// Storage is reset so the head reads as zero until the first push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int Depth = 2,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    fetch_entry_t          mem [Depth];
    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       rd_ptr;
    logic                  push_en;
    logic                  pop_en;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are power-of-two wide, so plain increment wraps modulo Depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{(CntW-1){1'b0}}, push_en} - {{(CntW-1){1'b0}}, pop_en};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to instruction memory,
// buffers responses and hands {pc, instr} to decode; redirects flush everything.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              Width     = 32,
    parameter logic [Width-1:0] ResetPc  = '0,
    parameter int              FifoDepth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_enable,
    output logic [Width-1:0] imem_address,
    output logic             imem_valid,
    input  logic [Width-1:0] imem_data,
    input  logic             imem_ready,
    input  logic             imem_done,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [Width-1:0] if_instr,
    output logic [Width-1:0] if_pc
);

    localparam int               CntW   = $clog2(FifoDepth) + 1;
    localparam logic [Width-1:0] PcStep = Width'(Width / 8);

    // Handshakes: a transfer happens on a cycle where valid && ready (decode side)
    // or valid && ready && done (memory side); valid never waits on ready.

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [Width-1:0] pc;
    logic             accept;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CntW-1:0]  fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (!fetch_enable) state_next = HALT;
            HALT:    if (fetch_enable) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // No look-ahead at a same-cycle pop: a full FIFO bubbles the request once.
    assign imem_valid   = (state == RUN) && (fifo_count < CntW'(FifoDepth)) && !redirect_valid;
    assign imem_address = pc;
    assign accept       = imem_valid && imem_ready && imem_done;

    // A redirect masks imem_valid, so any same-cycle response is dropped as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ResetPc;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[Width-1:InstrAlignBits], {InstrAlignBits{1'b0}}};
        end else if (accept) begin
            pc <= pc + PcStep;
        end
    end

    assign push_entry = '{pc: pc, instr: imem_data};
    assign if_valid   = !fifo_empty && !redirect_valid;
    assign pop        = if_valid && if_ready;
    assign if_pc      = head.pc;
    assign if_instr   = head.instr;

    fetch_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept && !fifo_full),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven memory model with programmable latency,
// a {pc, instr} scoreboard fed on each served request and drained on each pop.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_enable;
    logic [31:0] imem_address;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        imem_done;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pops   = 0;
    int          mem_delay;
    int          lat_cnt;
    logic        done_force;
    logic [31:0] exp_pc;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .Width     (32),
        .ResetPc   (32'h0),
        .FifoDepth (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable   (fetch_enable),
        .imem_address   (imem_address),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .imem_ready     (imem_ready),
        .imem_done      (imem_done),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00000013;
            32'h4:   return 32'h00100093;
            32'h8:   return 32'h00200113;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign imem_data = mem_word(imem_address);
    assign imem_done = done_force | (imem_valid && (lat_cnt >= mem_delay));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lat_cnt <= 0;
        else if (imem_valid && imem_ready && !imem_done) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end

    // Scoreboard sample at the falling edge: pops compared first, then redirect/serve.
    task automatic sb_sample();
        logic [63:0] e;
        if (!rst_n) begin
            exp_q.delete();
            exp_pc = 32'h0;
            return;
        end
        if (if_valid && if_ready) begin
            n_pops++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_pop: got pc=%h instr=%h want none", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                if ({if_pc, if_instr} !== e) $display("FAIL sb_pop: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, e[63:32], e[31:0]);
                else n_pass++;
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (imem_valid && imem_ready && imem_done) begin
            n_checks++;
            if (imem_address !== exp_pc) $display("FAIL sb_req_addr: got %h want %h", imem_address, exp_pc);
            else n_pass++;
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        drive_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_run();
        fetch_enable = 1'b1; if_ready = 1'b1; mem_delay = 0;
        rst_n = 1'b0;
        tick();
        n_checks++; if (imem_valid !== 1'b0) $display("FAIL reset_imem_valid: got %h want 0", imem_valid); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %h want 0", if_valid); else n_pass++;
        n_checks++; if ({if_pc, if_instr} !== 64'h0) $display("FAIL reset_if_data: got %h want 0", {if_pc, if_instr}); else n_pass++;
        n_checks++; if (imem_address !== 32'h0) $display("FAIL reset_address: got %h want 0", imem_address); else n_pass++;
        drive_edge();
        rst_n = 1'b1;
        tick();
        n_checks++; if (imem_valid !== 1'b0) $display("FAIL boot_no_request: got %h want 0", imem_valid); else n_pass++;
        tick();
        n_checks++; if ({imem_valid, imem_address} !== {1'b1, 32'h0}) $display("FAIL first_request: got %h want %h", {imem_valid, imem_address}, {1'b1, 32'h0}); else n_pass++;
        tick();
        n_checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h00000013}) $display("FAIL run_head0: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h0, 32'h00000013}); else n_pass++;
        tick();
        n_checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'h00100093}) $display("FAIL run_head1: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h4, 32'h00100093}); else n_pass++;
        tick();
        n_checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8, 32'h00200113}) $display("FAIL run_head2: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h8, 32'h00200113}); else n_pass++;
    endtask

    task automatic test_backpressure();
        int pops_before;
        if_ready = 1'b0; fetch_enable = 1'b1; mem_delay = 0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if ({imem_valid, imem_address} !== {1'b0, 32'h8}) $display("FAIL bp_full_stall: got %h want %h", {imem_valid, imem_address}, {1'b0, 32'h8}); else n_pass++;
        n_checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h00000013}) $display("FAIL bp_head_held: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h0, 32'h00000013}); else n_pass++;
        tick();
        n_checks++; if ({imem_address, if_pc} !== {32'h8, 32'h0}) $display("FAIL bp_stable: got %h want %h", {imem_address, if_pc}, {32'h8, 32'h0}); else n_pass++;
        pops_before = n_pops;
        drive_edge();
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        drive_edge();
        fetch_enable = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if ((n_pops - pops_before) < 3) $display("FAIL bp_delivered: got %0d want >=3", n_pops - pops_before); else n_pass++;
        n_checks++; if ({if_valid, 32'(exp_q.size())} !== 33'h0) $display("FAIL bp_drained: got if_valid=%h left=%0d want 0 0", if_valid, exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect();
        drive_edge();
        fetch_enable = 1'b1; if_ready = 1'b0; mem_delay = 0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if ({imem_valid, if_valid} !== 2'b01) $display("FAIL rd_prefull: got %b want 01", {imem_valid, if_valid}); else n_pass++;
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h40; done_force = 1'b1; if_ready = 1'b1;
        tick();
        n_checks++; if ({imem_valid, if_valid} !== 2'b00) $display("FAIL rd_same_cycle: got %b want 00", {imem_valid, if_valid}); else n_pass++;
        drive_edge();
        redirect_valid = 1'b0; done_force = 1'b0;
        tick();
        n_checks++; if ({if_valid, imem_valid, imem_address} !== {2'b01, 32'h40}) $display("FAIL rd_target_req: got %h want %h", {if_valid, imem_valid, imem_address}, {2'b01, 32'h40}); else n_pass++;
        tick();
        n_checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, mem_word(32'h40)}) $display("FAIL rd_first_head: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h40, mem_word(32'h40)}); else n_pass++;
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h46;
        tick();
        drive_edge();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (imem_address !== 32'h44) $display("FAIL rd_misaligned: got %h want %h", imem_address, 32'h44); else n_pass++;
        drive_edge();
        imem_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (imem_address !== 32'h48) $display("FAIL not_ready_hold: got %h want %h", imem_address, 32'h48); else n_pass++;
        drive_edge();
        imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        drive_edge();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (imem_address !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want %h", imem_address, 32'hFFFF_FFFC); else n_pass++;
        tick();
        n_checks++; if (imem_address !== 32'h0) $display("FAIL wrap_pc: got %h want 0", imem_address); else n_pass++;
    endtask

    task automatic test_slow_mem_enable();
        fetch_enable = 1'b1; if_ready = 1'b0; mem_delay = 3;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if ({imem_valid, imem_done, imem_address} !== {1'b1, (i == 3), 32'h0}) $display("FAIL slow_wait%0d: got %h want %h", i, {imem_valid, imem_done, imem_address}, {1'b1, (i == 3), 32'h0}); else n_pass++;
        end
        tick();
        n_checks++; if ({imem_address, if_valid, if_pc} !== {32'h4, 1'b1, 32'h0}) $display("FAIL slow_single_push: got %h want %h", {imem_address, if_valid, if_pc}, {32'h4, 1'b1, 32'h0}); else n_pass++;
        drive_edge();
        fetch_enable = 1'b0;
        tick();
        drive_edge();
        tick();
        n_checks++; if ({imem_valid, imem_address} !== {1'b0, 32'h4}) $display("FAIL halt_abandon: got %h want %h", {imem_valid, imem_address}, {1'b0, 32'h4}); else n_pass++;
        drive_edge();
        if_ready = 1'b1;
        tick();
        tick();
        n_checks++; if ({if_valid, imem_address} !== {1'b0, 32'h4}) $display("FAIL halt_drain: got %h want %h", {if_valid, imem_address}, {1'b0, 32'h4}); else n_pass++;
        drive_edge();
        fetch_enable = 1'b1; mem_delay = 0;
        tick();
        n_checks++; if (imem_valid !== 1'b0) $display("FAIL resume_registered: got %h want 0", imem_valid); else n_pass++;
        tick();
        n_checks++; if ({imem_valid, imem_address} !== {1'b1, 32'h4}) $display("FAIL resume_pc: got %h want %h", {imem_valid, imem_address}, {1'b1, 32'h4}); else n_pass++;
        tick();
        n_checks++; if (imem_address !== 32'h8) $display("FAIL resume_advance: got %h want %h", imem_address, 32'h8); else n_pass++;
    endtask

    task automatic test_async_reset();
        drive_edge();
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        drive_edge();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if ({if_valid, if_pc} !== {1'b1, 32'h80}) $display("FAIL ar_pre: got %h want %h", {if_valid, if_pc}, {1'b1, 32'h80}); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({imem_valid, if_valid, if_pc, if_instr, imem_address} !== 98'h0) $display("FAIL ar_immediate: got %h want 0", {imem_valid, if_valid, if_pc, if_instr, imem_address}); else n_pass++;
        tick();
        drive_edge();
        rst_n = 1'b1; if_ready = 1'b1;
        tick();
        n_checks++; if ({imem_valid, imem_address} !== {1'b0, 32'h0}) $display("FAIL ar_boot: got %h want %h", {imem_valid, imem_address}, {1'b0, 32'h0}); else n_pass++;
        tick();
        n_checks++; if ({imem_valid, imem_address} !== {1'b1, 32'h0}) $display("FAIL ar_restart: got %h want %h", {imem_valid, imem_address}, {1'b1, 32'h0}); else n_pass++;
        drive_edge();
        fetch_enable = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (exp_q.size() != 0) $display("FAIL final_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; fetch_enable = 1'b0; imem_ready = 1'b1; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; done_force = 1'b0;
        mem_delay = 0; exp_pc = 32'h0;
        test_reset_run();
        test_backpressure();
        test_redirect();
        test_slow_mem_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule
